// File: rtl/otter_cu_fsm.sv
// Multi-cycle control FSM for the OTTER RV32I core: sequences fetch/exec/writeback/trap,
// decodes the opcode into datapath strobes and counts retired instructions.
module otter_cu_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [6:0]       OPCODE,
  input  logic [2:0]       FUNC3,
  input  logic             INTR,
  input  logic             CSR_MIE,
  output logic             MEM_RDEN1,
  output logic             MEM_RDEN2,
  output logic             MEM_WE2,
  output logic             PC_WRITE,
  output logic             REG_WRITE,
  output logic             CSR_WE,
  output logic [1:0]       RF_WR_SEL,
  output logic             INT_TAKEN,
  output logic             MRET_EXEC,
  output logic             ILLEGAL,
  output logic [CNT_W-1:0] RETIRED
);

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WB    = 3'd3,
    ST_INTR  = 3'd4
  } state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] SEL_PC4 = 2'd0;
  localparam logic [1:0] SEL_CSR = 2'd1;
  localparam logic [1:0] SEL_MEM = 2'd2;
  localparam logic [1:0] SEL_ALU = 2'd3;

  state_t state, state_nxt;
  logic   complete;
  logic   trap_req;

  assign trap_req = INTR && CSR_MIE;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_INIT;
    else     state <= state_nxt;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)           RETIRED <= '0;
    else if (complete) RETIRED <= RETIRED + 1'b1;
  end

  always_comb begin
    state_nxt = state;
    complete  = 1'b0;
    MEM_RDEN1 = 1'b0;
    MEM_RDEN2 = 1'b0;
    MEM_WE2   = 1'b0;
    PC_WRITE  = 1'b0;
    REG_WRITE = 1'b0;
    CSR_WE    = 1'b0;
    RF_WR_SEL = SEL_PC4;
    INT_TAKEN = 1'b0;
    MRET_EXEC = 1'b0;
    ILLEGAL   = 1'b0;

    case (state)
      ST_INIT: state_nxt = ST_FETCH;

      ST_FETCH: begin
        MEM_RDEN1 = 1'b1;
        state_nxt = ST_EXEC;
      end

      ST_EXEC: begin
        complete = 1'b1;
        PC_WRITE = 1'b1;
        case (OPCODE)
          OP_LUI, OP_AUIPC, OP_OP, OP_IMM: begin
            REG_WRITE = 1'b1;
            RF_WR_SEL = SEL_ALU;
          end
          OP_JAL, OP_JALR: REG_WRITE = 1'b1;
          OP_BRANCH: ;
          OP_STORE:  MEM_WE2 = 1'b1;
          OP_LOAD: begin
            // Loads finish in WB once the data read has returned.
            complete  = 1'b0;
            PC_WRITE  = 1'b0;
            MEM_RDEN2 = 1'b1;
          end
          OP_SYSTEM: begin
            if (FUNC3 == 3'b001) begin
              REG_WRITE = 1'b1;
              CSR_WE    = 1'b1;
              RF_WR_SEL = SEL_CSR;
            end else if (FUNC3 == 3'b000) begin
              MRET_EXEC = 1'b1;
            end else begin
              ILLEGAL = 1'b1;
            end
          end
          default: ILLEGAL = 1'b1;
        endcase
        if (!complete)     state_nxt = ST_WB;
        else if (trap_req) state_nxt = ST_INTR;
        else               state_nxt = ST_FETCH;
      end

      ST_WB: begin
        complete  = 1'b1;
        PC_WRITE  = 1'b1;
        REG_WRITE = 1'b1;
        RF_WR_SEL = SEL_MEM;
        state_nxt = trap_req ? ST_INTR : ST_FETCH;
      end

      // Always returns to FETCH, so a trap is never taken twice without a retirement between.
      ST_INTR: begin
        INT_TAKEN = 1'b1;
        PC_WRITE  = 1'b1;
        state_nxt = ST_FETCH;
      end

      default: state_nxt = ST_INIT;
    endcase
  end

endmodule

// File: tb/tb_otter_cu_fsm.sv
// Directed table-driven bench for otter_cu_fsm; narrow counter so wrap-around is reachable.
module tb_otter_cu_fsm;

  localparam int CW = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [6:0]    opcode = 7'b0;
  logic [2:0]    func3 = 3'b0;
  logic          intr = 1'b0;
  logic          mie = 1'b0;
  logic          mem_rden1, mem_rden2, mem_we2, pc_write, reg_write, csr_we;
  logic [1:0]    rf_wr_sel;
  logic          int_taken, mret_exec, illegal;
  logic [CW-1:0] retired;
  logic [10:0]   outs;

  int errors = 0;
  int checks = 0;
  int exp_ret = 0;
  int int_seen = 0;

  otter_cu_fsm #(.CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST), .OPCODE(opcode), .FUNC3(func3), .INTR(intr), .CSR_MIE(mie),
    .MEM_RDEN1(mem_rden1), .MEM_RDEN2(mem_rden2), .MEM_WE2(mem_we2),
    .PC_WRITE(pc_write), .REG_WRITE(reg_write), .CSR_WE(csr_we), .RF_WR_SEL(rf_wr_sel),
    .INT_TAKEN(int_taken), .MRET_EXEC(mret_exec), .ILLEGAL(illegal), .RETIRED(retired)
  );

  always #5 CLK = ~CLK;

  // {rden1, rden2, we2, pc_write, reg_write, csr_we, sel[1:0], int_taken, mret, illegal}
  assign outs = {mem_rden1, mem_rden2, mem_we2, pc_write, reg_write, csr_we,
                 rf_wr_sel, int_taken, mret_exec, illegal};

  localparam logic [10:0] O_ZERO  = 11'b000_0_0_0_00_000;
  localparam logic [10:0] O_FETCH = 11'b100_0_0_0_00_000;
  localparam logic [10:0] O_ALU   = 11'b000_1_1_0_11_000;
  localparam logic [10:0] O_JMP   = 11'b000_1_1_0_00_000;
  localparam logic [10:0] O_BR    = 11'b000_1_0_0_00_000;
  localparam logic [10:0] O_ST    = 11'b001_1_0_0_00_000;
  localparam logic [10:0] O_LD    = 11'b010_0_0_0_00_000;
  localparam logic [10:0] O_CSR   = 11'b000_1_1_1_01_000;
  localparam logic [10:0] O_MRET  = 11'b000_1_0_0_00_010;
  localparam logic [10:0] O_ILL   = 11'b000_1_0_0_00_001;
  localparam logic [10:0] O_WB    = 11'b000_1_1_0_10_000;
  localparam logic [10:0] O_TRAP  = 11'b000_1_0_0_00_100;

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        ir;
    logic        ie;
    logic [10:0] exp_exec;
    logic        is_load;
    logic        exp_trap;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Starts in FETCH (just after an edge); runs one instruction through to the next FETCH.
  task automatic run_instr(input vec_t v);
    chk({v.name, " fetch"}, outs, O_FETCH);
    opcode = v.op; func3 = v.f3; intr = v.ir; mie = v.ie;
    step();
    #1;
    chk({v.name, " exec"}, outs, v.exp_exec);
    if (v.is_load) begin
      step();
      chk({v.name, " wb"}, outs, O_WB);
    end
    step();
    exp_ret = (exp_ret + 1) % (1 << CW);
    chk({v.name, " retired"}, retired, exp_ret);
    if (v.exp_trap) begin
      chk({v.name, " trap"}, outs, O_TRAP);
      intr = 1'b0;
      step();
      chk({v.name, " retired after trap"}, retired, exp_ret);
    end
    intr = 1'b0; mie = 1'b0;
  endtask

  always @(posedge CLK) if (int_taken) int_seen++;

  initial begin
    tbl[0]  = '{"op",        7'b0110011, 3'b000, 1'b0, 1'b0, O_ALU,  1'b0, 1'b0};
    tbl[1]  = '{"op_imm",    7'b0010011, 3'b000, 1'b0, 1'b0, O_ALU,  1'b0, 1'b0};
    tbl[2]  = '{"lui",       7'b0110111, 3'b000, 1'b0, 1'b0, O_ALU,  1'b0, 1'b0};
    tbl[3]  = '{"auipc",     7'b0010111, 3'b000, 1'b0, 1'b0, O_ALU,  1'b0, 1'b0};
    tbl[4]  = '{"jal",       7'b1101111, 3'b000, 1'b0, 1'b0, O_JMP,  1'b0, 1'b0};
    tbl[5]  = '{"jalr",      7'b1100111, 3'b000, 1'b0, 1'b0, O_JMP,  1'b0, 1'b0};
    tbl[6]  = '{"branch",    7'b1100011, 3'b001, 1'b0, 1'b0, O_BR,   1'b0, 1'b0};
    tbl[7]  = '{"store",     7'b0100011, 3'b010, 1'b0, 1'b0, O_ST,   1'b0, 1'b0};
    tbl[8]  = '{"load",      7'b0000011, 3'b010, 1'b0, 1'b0, O_LD,   1'b1, 1'b0};
    tbl[9]  = '{"load_irq",  7'b0000011, 3'b010, 1'b1, 1'b1, O_LD,   1'b1, 1'b1};
    tbl[10] = '{"csrrw_irq", 7'b1110011, 3'b001, 1'b1, 1'b1, O_CSR,  1'b0, 1'b1};
    tbl[11] = '{"mret_irq",  7'b1110011, 3'b000, 1'b1, 1'b1, O_MRET, 1'b0, 1'b1};
    tbl[12] = '{"sys_f3bad", 7'b1110011, 3'b010, 1'b0, 1'b0, O_ILL,  1'b0, 1'b0};
    tbl[13] = '{"illegal",   7'b1111111, 3'b000, 1'b0, 1'b0, O_ILL,  1'b0, 1'b0};
    tbl[14] = '{"op_masked", 7'b0110011, 3'b000, 1'b1, 1'b0, O_ALU,  1'b0, 1'b0};

    #12;
    chk("reset outs", outs, O_ZERO);
    chk("reset retired", retired, 0);
    RST = 1'b0;
    #1;
    chk("init outs", outs, O_ZERO);
    step();

    for (int i = 0; i < 15; i++) run_instr(tbl[i]);

    // Ten instructions with a masked interrupt: no trap, counter wraps 15 -> 9.
    int_seen = 0;
    for (int i = 0; i < 10; i++) begin
      chk("masked fetch", outs, O_FETCH);
      opcode = 7'b0010011; intr = 1'b1; mie = 1'b0;
      step();
      chk("masked exec", outs, O_ALU);
      step();
    end
    intr = 1'b0;
    exp_ret = (exp_ret + 10) % (1 << CW);
    chk("masked retired wrap", retired, exp_ret);
    chk("masked no trap", int_seen, 0);

    // Illegal opcode at the top of the counter range wraps to zero.
    while (exp_ret != (1 << CW) - 1) run_instr(tbl[0]);
    run_instr(tbl[13]);
    chk("illegal wrap", retired, 0);

    // Reset asserted mid-WB of a load.
    opcode = 7'b0000011; func3 = 3'b010;
    step();
    step();
    chk("pre-reset wb", outs, O_WB);
    RST = 1'b1;
    #1;
    chk("async reset outs", outs, O_ZERO);
    chk("async reset retired", retired, 0);
    #1;
    RST = 1'b0;
    #1;
    chk("post-reset init", outs, O_ZERO);
    step();
    exp_ret = 0;
    run_instr(tbl[0]);
    chk("resume retired", retired, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: sim did not complete");
    $fatal(1);
  end

endmodule
